// File: rtl/ahb_slave_regif_if.sv
// AHB-Lite signal bundle between the interconnect/master and the register-window slave.
interface ahb_slave_regif_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport slave (
        input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HSEL, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HSEL, HWDATA,
        input  HREADY, HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_slave_regif.sv
// AHB-Lite slave front-end for a NUM_REGS word register window: address qualification,
// wait-state insertion, single-cycle register strobes and two-cycle ERROR responses.
module ahb_slave_regif #(
    parameter logic [31:0] BASE_ADDR   = 32'hF0F0_0000,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned IDX_W       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    ahb_slave_regif_if.slave     bus,
    output logic [IDX_W-1:0]     reg_addr,
    output logic                 reg_wr,
    output logic                 reg_rd,
    output logic [31:0]          reg_wdata,
    input  logic [31:0]          reg_rdata,
    output logic                 invalid,
    output logic [15:0]          xfer_count,
    output logic [7:0]           err_count
);

    localparam int unsigned AW     = IDX_W + 2;
    localparam int unsigned WCNT_W = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ERR1   = 2'd2;
    localparam logic [1:0] S_ERR2   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              write_q, write_d;
    logic              hreadyout_q, hreadyout_d;
    logic              hresp_q, hresp_d;
    logic              reg_wr_q, reg_wr_d;
    logic              reg_rd_q, reg_rd_d;
    logic              invalid_q, invalid_d;
    logic [15:0]       xfer_count_q, xfer_count_d;
    logic [7:0]        err_count_q, err_count_d;

    logic accept;
    logic legal;
    logic can_accept;
    logic done_d;

    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign legal  = (bus.HADDR[31:AW] == BASE_ADDR[31:AW]) &&
                    (bus.HADDR[1:0] == 2'b00) && (bus.HSIZE == 3'b010);

    // New address phases are only taken while the bus sees us ready.
    assign can_accept = (state_q == S_IDLE) || (state_q == S_ERR2) ||
                        ((state_q == S_ACCESS) && (wcnt_q == '0));

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        write_d = write_q;

        case (state_q)
            S_IDLE:   state_d = S_IDLE;
            S_ACCESS: begin
                if (wcnt_q != '0) wcnt_d = wcnt_q - WCNT_W'(1);
                else              state_d = S_IDLE;
            end
            S_ERR1:   state_d = S_ERR2;
            default:  state_d = S_IDLE;
        endcase

        if (can_accept && accept) begin
            idx_d   = bus.HADDR[AW-1:2];
            write_d = bus.HWRITE;
            if (legal) begin
                state_d = S_ACCESS;
                wcnt_d  = WCNT_W'(WAIT_STATES);
            end else begin
                state_d = S_ERR1;
            end
        end

        // Outputs are registered copies of what the next state presents on the bus.
        done_d       = (state_d == S_ACCESS) && (wcnt_d == '0);
        hreadyout_d  = !(((state_d == S_ACCESS) && (wcnt_d != '0)) || (state_d == S_ERR1));
        hresp_d      = (state_d == S_ERR1) || (state_d == S_ERR2);
        reg_wr_d     = done_d & write_d;
        reg_rd_d     = done_d & ~write_d;
        invalid_d    = (state_d == S_ERR1);
        xfer_count_d = xfer_count_q + 16'(done_d);
        err_count_d  = (invalid_d && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            idx_q        <= '0;
            write_q      <= 1'b0;
            hreadyout_q  <= 1'b1;
            hresp_q      <= 1'b0;
            reg_wr_q     <= 1'b0;
            reg_rd_q     <= 1'b0;
            invalid_q    <= 1'b0;
            xfer_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            idx_q        <= idx_d;
            write_q      <= write_d;
            hreadyout_q  <= hreadyout_d;
            hresp_q      <= hresp_d;
            reg_wr_q     <= reg_wr_d;
            reg_rd_q     <= reg_rd_d;
            invalid_q    <= invalid_d;
            xfer_count_q <= xfer_count_d;
            err_count_q  <= err_count_d;
        end
    end

    // Read data is combinational from the register file at the registered index.
    assign bus.HRDATA    = reg_rd_q ? reg_rdata : 32'h0;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign reg_addr      = idx_q;
    assign reg_wr        = reg_wr_q;
    assign reg_rd        = reg_rd_q;
    assign reg_wdata     = bus.HWDATA;
    assign invalid       = invalid_q;
    assign xfer_count    = xfer_count_q;
    assign err_count     = err_count_q;

    logic unused_bus;
    assign unused_bus = ^{bus.HBURST, bus.HMASTLOCK, bus.HPROT, bus.HTRANS[0]};

endmodule

// File: tb/tb_ahb_slave_regif.sv
// Directed bench for ahb_slave_regif: a one-wait-state instance driven from a vector table
// plus a zero-wait instance for back-to-back bursts.
module tb_ahb_slave_regif;

    localparam int K_NONE = 0;
    localparam int K_OK   = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic        sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          kind;
        logic [3:0]  idx;
        logic [15:0] xfer;
        logic [7:0]  errc;
    } vec_t;

    logic clk;
    logic n_rst;
    int   n_cmp;
    int   n_bad;

    ahb_slave_regif_if bus();
    ahb_slave_regif_if bus0();

    logic [3:0]  reg_addr, reg_addr0;
    logic        reg_wr, reg_wr0, reg_rd, reg_rd0;
    logic [31:0] reg_wdata, reg_wdata0;
    logic [31:0] reg_rdata, reg_rdata0;
    logic        invalid, invalid0;
    logic [15:0] xfer_count, xfer_count0;
    logic [7:0]  err_count, err_count0;

    assign bus.HREADY  = bus.HREADYOUT;
    assign bus0.HREADY = bus0.HREADYOUT;

    ahb_slave_regif #(.WAIT_STATES(1)) u_dut (
        .clk(clk), .n_rst(n_rst), .bus(bus.slave),
        .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .invalid(invalid),
        .xfer_count(xfer_count), .err_count(err_count)
    );

    ahb_slave_regif #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .n_rst(n_rst), .bus(bus0.slave),
        .reg_addr(reg_addr0), .reg_wr(reg_wr0), .reg_rd(reg_rd0),
        .reg_wdata(reg_wdata0), .reg_rdata(reg_rdata0), .invalid(invalid0),
        .xfer_count(xfer_count0), .err_count(err_count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status word: {HREADYOUT, HRESP, reg_wr, reg_rd, invalid}
    function automatic logic [4:0] st();
        return {bus.HREADYOUT, bus.HRESP, reg_wr, reg_rd, invalid};
    endfunction

    function automatic logic [4:0] st0();
        return {bus0.HREADYOUT, bus0.HRESP, reg_wr0, reg_rd0, invalid0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge with the slave idle; returns at a negedge with the slave idle.
    task automatic apply_vec(input int n, input vec_t v);
        bus.HSEL   = v.sel;
        bus.HADDR  = v.addr;
        bus.HTRANS = v.trans;
        bus.HWRITE = v.wr;
        bus.HSIZE  = v.size;
        @(posedge clk);
        #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = v.wdata;
        reg_rdata  = v.rdata;
        @(negedge clk);
        case (v.kind)
            K_NONE: begin
                check($sformatf("v%0d idle status", n), 32'(st()), 32'h10);
            end
            K_OK: begin
                check($sformatf("v%0d wait status", n), 32'(st()), 32'h00);
                @(negedge clk);
                check($sformatf("v%0d done status", n), 32'(st()),
                      32'({1'b1, 1'b0, v.wr, ~v.wr, 1'b0}));
                check($sformatf("v%0d reg_addr", n), 32'(reg_addr), 32'(v.idx));
                check($sformatf("v%0d HRDATA", n), bus.HRDATA, v.wr ? 32'h0 : v.rdata);
                if (v.wr) check($sformatf("v%0d reg_wdata", n), reg_wdata, v.wdata);
                @(negedge clk);
                check($sformatf("v%0d after status", n), 32'(st()), 32'h10);
            end
            default: begin
                check($sformatf("v%0d err1 status", n), 32'(st()), 32'h09);
                @(negedge clk);
                check($sformatf("v%0d err2 status", n), 32'(st()), 32'h18);
                @(negedge clk);
                check($sformatf("v%0d after status", n), 32'(st()), 32'h10);
            end
        endcase
        check($sformatf("v%0d xfer_count", n), 32'(xfer_count), 32'(v.xfer));
        check($sformatf("v%0d err_count", n), 32'(err_count), 32'(v.errc));
    endtask

    vec_t vecs[13];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vecs[0]  = '{32'hF0F0_0008, 1'b1, 3'b010, 2'b10, 1'b1, 32'hDEAD_BEEF, 32'h0,         K_OK,   4'd2,  16'd1, 8'd0};
        vecs[1]  = '{32'hF0F0_003C, 1'b0, 3'b010, 2'b10, 1'b1, 32'h0,         32'h1234_5678, K_OK,   4'd15, 16'd2, 8'd0};
        vecs[2]  = '{32'hF0F0_0040, 1'b1, 3'b010, 2'b10, 1'b1, 32'h1111_1111, 32'h0,         K_ERR,  4'd0,  16'd2, 8'd1};
        vecs[3]  = '{32'hF0F0_0002, 1'b0, 3'b010, 2'b10, 1'b1, 32'h0,         32'h0,         K_ERR,  4'd0,  16'd2, 8'd2};
        vecs[4]  = '{32'hF0F0_0004, 1'b1, 3'b000, 2'b10, 1'b1, 32'h2222_2222, 32'h0,         K_ERR,  4'd0,  16'd2, 8'd3};
        vecs[5]  = '{32'hF0F0_0010, 1'b1, 3'b010, 2'b00, 1'b1, 32'h3333_3333, 32'h0,         K_NONE, 4'd0,  16'd2, 8'd3};
        vecs[6]  = '{32'hF0F0_0010, 1'b0, 3'b010, 2'b01, 1'b1, 32'h0,         32'h0,         K_NONE, 4'd0,  16'd2, 8'd3};
        vecs[7]  = '{32'hF0F0_0010, 1'b1, 3'b010, 2'b10, 1'b0, 32'h4444_4444, 32'h0,         K_NONE, 4'd0,  16'd2, 8'd3};
        vecs[8]  = '{32'hF0F0_0000, 1'b0, 3'b010, 2'b10, 1'b1, 32'h0,         32'hA5A5_5A5A, K_OK,   4'd0,  16'd3, 8'd3};
        vecs[9]  = '{32'hF0F0_FFFC, 1'b1, 3'b010, 2'b10, 1'b1, 32'h5555_5555, 32'h0,         K_ERR,  4'd0,  16'd3, 8'd4};
        vecs[10] = '{32'hF0EF_FFFC, 1'b0, 3'b010, 2'b10, 1'b1, 32'h0,         32'h0,         K_ERR,  4'd0,  16'd3, 8'd5};
        vecs[11] = '{32'hF0F0_0020, 1'b1, 3'b010, 2'b11, 1'b1, 32'h0BAD_F00D, 32'h0,         K_OK,   4'd8,  16'd4, 8'd5};
        vecs[12] = '{32'hF0F0_0008, 1'b0, 3'b001, 2'b10, 1'b1, 32'h0,         32'h0,         K_ERR,  4'd0,  16'd4, 8'd6};

        {bus.HADDR, bus.HBURST, bus.HMASTLOCK, bus.HPROT, bus.HSIZE} = '0;
        {bus.HTRANS, bus.HWRITE, bus.HSEL, bus.HWDATA} = '0;
        {bus0.HADDR, bus0.HBURST, bus0.HMASTLOCK, bus0.HPROT, bus0.HSIZE} = '0;
        {bus0.HTRANS, bus0.HWRITE, bus0.HSEL, bus0.HWDATA} = '0;
        reg_rdata  = 32'hFFFF_FFFF;
        reg_rdata0 = 32'hFFFF_FFFF;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        check("reset status", 32'(st()), 32'h10);
        check("reset HRDATA", bus.HRDATA, 32'h0);
        check("reset reg_addr", 32'(reg_addr), 32'h0);
        check("reset xfer_count", 32'(xfer_count), 32'h0);
        check("reset err_count", 32'(err_count), 32'h0);
        check("reset0 status", 32'(st0()), 32'h10);
        check("reset0 counters", 32'({xfer_count0, err_count0}), 32'h0);

        for (int i = 0; i < 13; i++) apply_vec(i, vecs[i]);

        // Zero-wait instance: NONSEQ then two SEQ writes, one per cycle.
        bus0.HSEL   = 1'b1;
        bus0.HADDR  = 32'hF0F0_0000;
        bus0.HTRANS = 2'b10;
        bus0.HWRITE = 1'b1;
        bus0.HSIZE  = 3'b010;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk);
            #1;
            bus0.HWDATA = 32'hC0DE_0000 + 32'(b);
            if (b < 2) begin
                bus0.HADDR  = 32'hF0F0_0000 + 32'(4 * (b + 1));
                bus0.HTRANS = 2'b11;
            end else begin
                bus0.HSEL   = 1'b0;
                bus0.HTRANS = 2'b00;
            end
            @(negedge clk);
            check($sformatf("burst%0d status", b), 32'(st0()), 32'h14);
            check($sformatf("burst%0d reg_addr", b), 32'(reg_addr0), 32'(b));
            check($sformatf("burst%0d reg_wdata", b), reg_wdata0, 32'hC0DE_0000 + 32'(b));
        end
        @(negedge clk);
        check("burst end status", 32'(st0()), 32'h10);
        check("burst xfer_count", 32'(xfer_count0), 32'd3);

        // Reset asserted during the wait cycle of a legal write.
        bus.HSEL   = 1'b1;
        bus.HADDR  = 32'hF0F0_0004;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        bus.HSIZE  = 3'b010;
        @(posedge clk);
        #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        @(negedge clk);
        check("pre-reset wait status", 32'(st()), 32'h00);
        n_rst = 1'b0;
        #1;
        check("async reset status", 32'(st()), 32'h10);
        check("async reset counters", 32'({xfer_count, err_count}), 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("post-reset status", 32'(st()), 32'h10);

        // 260 back-to-back illegal accesses; each new one is taken in ERR2.
        bus.HADDR  = 32'h0000_0000;
        bus.HWRITE = 1'b0;
        for (int i = 0; i < 260; i++) begin
            bus.HSEL   = 1'b1;
            bus.HTRANS = 2'b10;
            @(posedge clk);
            #1;
            bus.HSEL   = 1'b0;
            bus.HTRANS = 2'b00;
            @(negedge clk);
            if (i == 0)   check("sat first err_count", 32'(err_count), 32'h01);
            if (i == 253) check("sat err_count 254", 32'(err_count), 32'hFE);
            if (i == 259) check("sat last err1 status", 32'(st()), 32'h09);
            @(negedge clk);
            if (i == 259) check("sat last err2 status", 32'(st()), 32'h18);
        end
        @(negedge clk);
        check("sat end status", 32'(st()), 32'h10);
        check("sat err_count", 32'(err_count), 32'hFF);
        check("sat xfer_count", 32'(xfer_count), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
